// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC argument-reduction
// front end.
//   - FRAC_DEFAULT / OUT_FRAC_DEFAULT : default fixed-point fraction widths
//   - TWO_OVER_PI (Q1.30), PIO2 (Q2.32): reduction constants
//   - IEEE-754 single field widths and exponent bias
//   - quadrant_e : how the CORDIC core interprets the 2-bit quadrant
package cordic_pkg;

  localparam int unsigned FRAC_DEFAULT     = 28;
  localparam int unsigned OUT_FRAC_DEFAULT = 30;

  // Internal datapath widths: x is signed Q3.FRAC in X_W bits, k is the
  // rounded quotient (-5..5), RES_W holds x - k*pi/2 with 32 fraction bits.
  localparam int unsigned X_W   = 32;
  localparam int unsigned K_W   = 4;
  localparam int unsigned RES_W = 40;

  localparam int unsigned FLOAT_W  = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int          EXP_BIAS = 127;
  // 2^(130-127) = 8.0 no longer fits the Q3 integer field.
  localparam int          RANGE_EXP = 130;

  localparam int unsigned        TWO_OVER_PI_FRAC = 30;
  localparam logic signed [31:0] TWO_OVER_PI      = 32'sh28BE60DC;
  localparam int unsigned        PIO2_FRAC        = 32;
  localparam logic signed [35:0] PIO2             = 36'sh1_921F_B544;

  // 0 -> sin r, 1 -> cos r, 2 -> -sin r, 3 -> -cos r
  typedef enum logic [1:0] {
    QUAD_SIN     = 2'd0,
    QUAD_COS     = 2'd1,
    QUAD_NEG_SIN = 2'd2,
    QUAD_NEG_COS = 2'd3
  } quadrant_e;

endpackage

// File: rtl/float_to_fixed.sv
// float_to_fixed: combinational unpack of an IEEE-754 single into signed
// Q3.FRAC fixed point.
//   bits         : IEEE-754 single input
//   x            : signed Q3.FRAC value (0 for zero/denormal/flagged inputs)
//   invalid      : input is NaN or +/-Inf
//   out_of_range : finite input with |value| >= 8.0
module float_to_fixed
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC = FRAC_DEFAULT
) (
  input  logic [FLOAT_W-1:0]    bits,
  output logic signed [X_W-1:0] x,
  output logic                  invalid,
  output logic                  out_of_range
);

  logic              sign;
  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W:0]   mant;
  logic [X_W-1:0]    mag;
  int                shift;

  always_comb begin
    sign         = bits[FLOAT_W-1];
    exp_f        = bits[FLOAT_W-2 -: EXP_W];
    mant         = {1'b1, bits[MANT_W-1:0]};
    mag          = '0;
    invalid      = 1'b0;
    out_of_range = 1'b0;
    shift        = 0;
    if (exp_f == '1) begin
      invalid = 1'b1;
    end else if (int'(exp_f) >= RANGE_EXP) begin
      out_of_range = 1'b1;
    end else if (exp_f != '0) begin
      shift = int'(exp_f) - EXP_BIAS + int'(FRAC) - int'(MANT_W);
      if (shift >= 0) begin
        mag = {{(X_W-MANT_W-1){1'b0}}, mant} << shift;
      end else begin
        // Right shift drops bits, i.e. truncates the magnitude toward zero.
        mag = {{(X_W-MANT_W-1){1'b0}}, mant} >> (-shift);
      end
    end
    x = sign ? -mag : mag;
  end

endmodule

// File: rtl/cordic_range_reduce.sv
// cordic_range_reduce: 3-stage argument reduction in front of the CORDIC
// rotation core. Maps a float angle x to r + q*pi/2 with r in ~[-pi/4, pi/4].
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   io_in_valid/ready  : input handshake; ready drops while the output stalls
//   io_in_bits         : IEEE-754 single angle in radians
//   io_out_valid/ready : output handshake
//   io_out_angle       : residual r, signed Q1.OUT_FRAC
//   io_out_quadrant    : k mod 4
//   io_out_invalid     : input was NaN/Inf
//   io_out_range       : finite input with |x| >= 8.0
module cordic_range_reduce
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC     = FRAC_DEFAULT,
  parameter int unsigned OUT_FRAC = OUT_FRAC_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [FLOAT_W-1:0]  io_in_bits,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [OUT_FRAC+1:0] io_out_angle,
  output logic [1:0]          io_out_quadrant,
  output logic                io_out_invalid,
  output logic                io_out_range
);

  localparam int unsigned PW        = 2 * X_W;
  localparam int unsigned AW        = OUT_FRAC + 2;
  localparam int unsigned PROD_FRAC = FRAC + TWO_OVER_PI_FRAC;
  localparam int unsigned ALIGN     = PIO2_FRAC - FRAC;
  localparam int unsigned DROP      = PIO2_FRAC - OUT_FRAC;

  logic advance;

  logic                  s1_valid, s1_invalid, s1_range;
  logic signed [X_W-1:0] s1_x;
  logic                  s2_valid, s2_invalid, s2_range;
  logic signed [X_W-1:0] s2_x;
  logic signed [K_W-1:0] s2_k;
  logic                  s3_valid, s3_invalid, s3_range;
  logic [AW-1:0]         s3_angle;
  quadrant_e             s3_quad;

  logic signed [X_W-1:0]   unpack_x;
  logic                    unpack_invalid, unpack_range;
  logic signed [PW-1:0]    prod_rnd;
  logic signed [K_W-1:0]   k_next;
  logic signed [RES_W-1:0] diff;
  logic [AW-1:0]           angle_next;

  float_to_fixed #(.FRAC(FRAC)) u_unpack (
    .bits         (io_in_bits),
    .x            (unpack_x),
    .invalid      (unpack_invalid),
    .out_of_range (unpack_range)
  );

  // Flagged inputs arrive with x=0, so k and r fall out as 0 on their own.
  always_comb begin
    // floor(p + 0.5): bias by half an LSB of k, then arithmetic shift floors.
    prod_rnd   = PW'(s1_x) * PW'(TWO_OVER_PI) + (PW'(1) <<< (PROD_FRAC - 1));
    k_next     = K_W'(prod_rnd >>> PROD_FRAC);
    diff       = (RES_W'(s2_x) <<< ALIGN) - RES_W'(s2_k) * RES_W'(PIO2);
    angle_next = AW'(diff >>> DROP);
  end

  // The whole pipe freezes only when a valid result is being held back.
  assign advance     = !(s3_valid && !io_out_ready);
  assign io_in_ready = advance;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_invalid <= 1'b0;
      s1_range   <= 1'b0;
      s1_x       <= '0;
      s2_valid   <= 1'b0;
      s2_invalid <= 1'b0;
      s2_range   <= 1'b0;
      s2_x       <= '0;
      s2_k       <= '0;
      s3_valid   <= 1'b0;
      s3_invalid <= 1'b0;
      s3_range   <= 1'b0;
      s3_angle   <= '0;
      s3_quad    <= QUAD_SIN;
    end else if (advance) begin
      s1_valid   <= io_in_valid;
      s1_invalid <= unpack_invalid;
      s1_range   <= unpack_range;
      s1_x       <= unpack_x;
      s2_valid   <= s1_valid;
      s2_invalid <= s1_invalid;
      s2_range   <= s1_range;
      s2_x       <= s1_x;
      s2_k       <= k_next;
      s3_valid   <= s2_valid;
      s3_invalid <= s2_invalid;
      s3_range   <= s2_range;
      s3_angle   <= angle_next;
      s3_quad    <= quadrant_e'(s2_k[1:0]);
    end
  end

  assign io_out_valid    = s3_valid;
  assign io_out_angle    = s3_angle;
  assign io_out_quadrant = s3_quad;
  assign io_out_invalid  = s3_invalid;
  assign io_out_range    = s3_range;

endmodule
